// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared state encoding and block width for the AES block controller
package aes_ctrl_pkg;
  localparam int BLOCK_W = 128;
  typedef enum logic [2:0] {IDLE, KEY, FETCH, RUN, DRAIN, FINISH, ERR} ctrl_state_e;
endpackage

// File: rtl/aes_watchdog.sv
// aes_watchdog: per-operation cycle counter flagging an operation that ran TIMEOUT cycles
// ports: clk, rst (async), clr (sync restart), en (operation in progress), expired (TIMEOUT-th cycle reached)
module aes_watchdog #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [TO_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
  // the count starts at 0 in the first cycle, so TIMEOUT-1 marks the TIMEOUT-th cycle
  assign expired = en && cnt == TO_W'(TIMEOUT - 1);
endmodule

// File: rtl/aes_block_ctrl.sv
// aes_block_ctrl: sequences one AES block engine through an N-block job with optional rekey and watchdog
// ports: stacker in (in_valid/in_ready/in_data), key engine (key_start/key_done),
//        block core (core_start/core_data_o/core_done/core_data_i), unstacker out (out_valid/out_ready/out_data),
//        control status (start/nblocks/rekey/clr in; busy/done/err/blk_cnt out)
module aes_block_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               start_i,
  input  logic [CNT_W-1:0]   nblocks_i,
  input  logic               rekey_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [BLOCK_W-1:0] in_data_i,
  output logic               key_start_o,
  input  logic               key_done_i,
  output logic               core_start_o,
  output logic [BLOCK_W-1:0] core_data_o,
  input  logic               core_done_i,
  input  logic [BLOCK_W-1:0] core_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [BLOCK_W-1:0] out_data_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [CNT_W-1:0]   blk_cnt_o
);
  ctrl_state_e state, nxt;
  logic [CNT_W-1:0] rem_r;
  logic st_ok, wd_entry, expired;
  assign st_ok = start_i && (state == IDLE || state == ERR);
  always_comb begin
    nxt = state;
    case (state)
      IDLE, ERR: if (st_ok) nxt = nblocks_i == '0 ? FINISH : rekey_i ? KEY : FETCH;
      KEY:       nxt = key_done_i ? FETCH : expired ? ERR : KEY;
      FETCH:     nxt = in_valid_i ? RUN : FETCH;
      RUN:       nxt = core_done_i ? DRAIN : expired ? ERR : RUN;
      DRAIN:     nxt = !out_ready_i ? DRAIN : rem_r == CNT_W'(1) ? FINISH : FETCH;
      FINISH:    nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end
  assign wd_entry = nxt != state && (nxt == KEY || nxt == RUN);
  aes_watchdog #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk_i), .rst(rst_i), .clr(clr_i || wd_entry),
    .en(state == KEY || state == RUN), .expired(expired)
  );
  // outputs are registered from the next state so they line up exactly with the state they describe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      rem_r        <= '0;
      in_ready_o   <= 1'b0;
      key_start_o  <= 1'b0;
      core_start_o <= 1'b0;
      out_valid_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      blk_cnt_o    <= '0;
      core_data_o  <= '0;
      out_data_o   <= '0;
    end else if (clr_i) begin
      state        <= IDLE;
      rem_r        <= '0;
      in_ready_o   <= 1'b0;
      key_start_o  <= 1'b0;
      core_start_o <= 1'b0;
      out_valid_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      blk_cnt_o    <= '0;
      core_data_o  <= '0;
      out_data_o   <= '0;
    end else begin
      state        <= nxt;
      in_ready_o   <= nxt == FETCH;
      key_start_o  <= nxt == KEY && state != KEY;
      core_start_o <= nxt == RUN && state != RUN;
      out_valid_o  <= nxt == DRAIN;
      busy_o       <= nxt != IDLE && nxt != ERR;
      done_o       <= nxt == FINISH;
      // sticky while parked in ERR; a new accepted start leaves ERR and clears it
      err_o        <= nxt == ERR;
      if (st_ok) begin
        rem_r     <= nblocks_i;
        blk_cnt_o <= '0;
      end
      if (state == FETCH && in_valid_i) core_data_o <= in_data_i;
      if (state == RUN && core_done_i) out_data_o <= core_data_i;
      if (state == DRAIN && out_ready_i) begin
        blk_cnt_o <= blk_cnt_o + 1'b1;
        rem_r     <= rem_r - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_aes_block_ctrl.sv
// tb_aes_block_ctrl: scoreboard bench with stacker/core/key/unstacker models around aes_block_ctrl
module tb_aes_block_ctrl;
  localparam int CNT_W = 16, TO_W = 8, TIMEOUT = 200;
  logic clk = 0, rst_i = 0, clr_i = 0, start_i = 0, rekey_i = 0;
  logic in_valid_i = 0, key_done_i = 0, core_done_i = 0, out_ready_i = 0;
  logic [CNT_W-1:0] nblocks_i = '0;
  logic [127:0] in_data_i = '0, core_data_i = '0;
  logic in_ready_o, key_start_o, core_start_o, out_valid_o, busy_o, done_o, err_o;
  logic [127:0] core_data_o, out_data_o;
  logic [CNT_W-1:0] blk_cnt_o;

  aes_block_ctrl #(.CNT_W(CNT_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .start_i(start_i), .nblocks_i(nblocks_i),
    .rekey_i(rekey_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .key_start_o(key_start_o), .key_done_i(key_done_i), .core_start_o(core_start_o),
    .core_data_o(core_data_o), .core_done_i(core_done_i), .core_data_i(core_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .blk_cnt_o(blk_cnt_o)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic fail_to(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not seen within budget (got 0 expected 1)", nm);
  endtask

  // scoreboard: blocks waiting in the stacker, expected results, expected blk_cnt per finished job
  logic [127:0] stack_q[$], exp_q[$];
  int exp_done[$];

  bit core_hold = 0, man_done = 0, rnd_ready = 0, ready_force = 1;
  int core_lat = 10, key_lat = 5, cd_cnt = 0, ks_cnt = 0;
  logic [127:0] cd_data = '0;

  // environment: stacker source, core and key engine models, unstacker sink
  initial begin
    bit hs_in;
    forever begin
      @(negedge clk);
      hs_in = in_valid_i && in_ready_o;
      if (hs_in) exp_q.push_back(in_data_i ^ 128'd1);
      if (core_start_o && !core_hold) begin
        cd_cnt = core_lat;
        cd_data = core_data_o;
      end
      if (key_start_o) ks_cnt = key_lat;
      @(posedge clk);
      #1;
      if (hs_in) void'(stack_q.pop_front());
      in_valid_i = stack_q.size() != 0 && ((in_valid_i && !hs_in) || $urandom_range(0, 2) != 0);
      in_data_i = stack_q.size() != 0 ? stack_q[0] : '0;
      core_done_i = man_done;
      if (cd_cnt > 0) begin
        cd_cnt--;
        if (cd_cnt == 0) begin
          core_done_i = 1;
          core_data_i = cd_data ^ 128'd1;
        end
      end
      key_done_i = 0;
      if (ks_cnt > 0) begin
        ks_cnt--;
        if (ks_cnt == 0) key_done_i = 1;
      end
      out_ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  int core_starts = 0, key_starts = 0, done_seen = 0;
  int last_hs = 0, done_cyc = 0, key_cyc = 0, cs_cyc = 0;
  bit key_pend = 0, pv = 0, pr = 0;
  logic [127:0] pdata = '0;

  // monitor: pops the scoreboard whenever the DUT presents a result or a job completion
  always @(negedge clk) begin
    if (out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL out_data: got unexpected %0h expected no result", out_data_o);
      end else chk("out_data", out_data_o, exp_q.pop_front());
      last_hs = cyc;
    end
    if (out_valid_o && pv && !pr) chk("out_hold", out_data_o, pdata);
    if (out_valid_o) chk("in_ready_in_drain", 128'(in_ready_o), '0);
    if (key_pend) chk("in_ready_during_key", 128'(in_ready_o), '0);
    if (key_start_o) begin
      key_starts++;
      key_cyc = cyc;
      key_pend = 1;
    end
    if (key_done_i) key_pend = 0;
    if (core_start_o) begin
      core_starts++;
      cs_cyc = cyc;
    end
    if (done_o) begin
      done_seen++;
      done_cyc = cyc;
      if (exp_done.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL done: got unexpected done expected none");
      end else chk("blk_cnt_at_done", 128'(blk_cnt_o), 128'(exp_done.pop_front()));
    end
    pv = out_valid_o;
    pr = out_ready_i;
    pdata = out_data_o;
  end

  int st_cyc = 0;
  task automatic start_job(input int n, input bit rk, input bit push_done);
    for (int i = 0; i < n; i++) stack_q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
    if (push_done) exp_done.push_back(n);
    @(posedge clk);
    #1;
    nblocks_i = CNT_W'(n);
    rekey_i = rk;
    start_i = 1;
    st_cyc = cyc;
    @(posedge clk);
    #1;
    start_i = 0;
  endtask

  task automatic wait_done(input string nm);
    int d0 = done_seen;
    int k = 0;
    while (done_seen == d0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (done_seen == d0) fail_to(nm);
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, "_busy"}, 128'(busy_o), '0);
    chk({nm, "_in_ready"}, 128'(in_ready_o), '0);
    chk({nm, "_out_valid"}, 128'(out_valid_o), '0);
    chk({nm, "_done"}, 128'(done_o), '0);
    chk({nm, "_err"}, 128'(err_o), '0);
    chk({nm, "_core_start"}, 128'(core_start_o), '0);
    chk({nm, "_key_start"}, 128'(key_start_o), '0);
    chk({nm, "_blk_cnt"}, 128'(blk_cnt_o), '0);
    chk({nm, "_core_data"}, core_data_o, '0);
    chk({nm, "_out_data"}, out_data_o, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (got hang expected finish)");
    $fatal(1);
  end

  initial begin
    int cs0, ks0, k, err_cyc;
    #1 rst_i = 1;
    #1 chk_idle_zero("reset");
    @(negedge clk) rst_i = 0;
    // three blocks, no rekey, sink always ready
    cs0 = core_starts;
    ks0 = key_starts;
    start_job(3, 0, 1);
    wait_done("job1_done");
    chk("job1_core_starts", 128'(core_starts - cs0), 128'd3);
    chk("job1_key_starts", 128'(key_starts - ks0), '0);
    chk("job1_done_after_hs", 128'(done_cyc - last_hs), 128'd1);
    @(negedge clk);
    chk("job1_busy_after", 128'(busy_o), '0);
    chk("job1_blk_cnt_hold", 128'(blk_cnt_o), 128'd3);
    // rekey then a single block
    cs0 = core_starts;
    ks0 = key_starts;
    key_lat = 5;
    start_job(1, 1, 1);
    wait_done("job2_done");
    chk("job2_key_start_delay", 128'(key_cyc - st_cyc), 128'd1);
    chk("job2_key_starts", 128'(key_starts - ks0), 128'd1);
    chk("job2_core_starts", 128'(core_starts - cs0), 128'd1);
    // empty job
    cs0 = core_starts;
    ks0 = key_starts;
    start_job(0, 1, 1);
    wait_done("job0_done");
    chk("job0_done_delay", 128'(done_cyc - st_cyc), 128'd1);
    chk("job0_core_starts", 128'(core_starts - cs0), '0);
    chk("job0_key_starts", 128'(key_starts - ks0), '0);
    chk("job0_blk_cnt", 128'(blk_cnt_o), '0);
    // core never answers: watchdog error
    core_hold = 1;
    start_job(1, 0, 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!err_o && k < 400);
    if (!err_o) fail_to("wdog_err");
    err_cyc = cyc;
    chk("wdog_run_cycles", 128'(err_cyc - cs_cyc), 128'(TIMEOUT));
    chk("wdog_busy", 128'(busy_o), '0);
    @(negedge clk);
    chk("wdog_err_sticky", 128'(err_o), 128'd1);
    exp_q.delete();
    core_hold = 0;
    start_job(1, 0, 1);
    @(negedge clk);
    chk("restart_err_clear", 128'(err_o), '0);
    chk("restart_busy", 128'(busy_o), 128'd1);
    wait_done("restart_done");
    // backpressure in DRAIN
    ready_force = 0;
    start_job(2, 0, 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid_o && k < 100);
    if (!out_valid_o) fail_to("bp_out_valid");
    cs0 = core_starts;
    repeat (20) begin
      @(negedge clk);
      chk("bp_out_valid_held", 128'(out_valid_o), 128'd1);
    end
    chk("bp_no_core_start", 128'(core_starts - cs0), '0);
    ready_force = 1;
    wait_done("bp_done");
    // randomized jobs with random sink readiness and latencies
    rnd_ready = 1;
    for (int j = 0; j < 8; j++) begin
      core_lat = $urandom_range(1, 12);
      key_lat = $urandom_range(1, 8);
      start_job($urandom_range(1, 4), 1'($urandom_range(0, 1)), 1);
      wait_done("rand_done");
    end
    chk("rand_results_drained", 128'(exp_q.size()), '0);
    chk("rand_done_drained", 128'(exp_done.size()), '0);
    rnd_ready = 0;
    ready_force = 1;
    // soft clear in RUN, late core_done must be ignored
    core_hold = 1;
    start_job(1, 0, 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!core_start_o && k < 100);
    if (!core_start_o) fail_to("clr_run");
    clr_i = 1;
    man_done = 1;
    @(negedge clk);
    chk_idle_zero("clr");
    clr_i = 0;
    man_done = 0;
    repeat (3) @(negedge clk);
    chk("clr_late_done_busy", 128'(busy_o), '0);
    chk("clr_late_done_valid", 128'(out_valid_o), '0);
    chk("clr_late_done_data", out_data_o, '0);
    exp_q.delete();
    core_hold = 0;
    // async reset in DRAIN, checked before any clock edge
    ready_force = 0;
    start_job(1, 0, 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid_o && k < 100);
    if (!out_valid_o) fail_to("rst_drain");
    #2 rst_i = 1;
    #1 chk_idle_zero("async_rst");
    @(negedge clk) rst_i = 0;
    exp_q.delete();
    ready_force = 1;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_block_ctrl.md
Name: aes_block_ctrl

Overview:
- Sequences a single 128-bit AES block engine for one job of N blocks.
- Upstream is the 32-to-128-bit word stacker (valid/ready). Downstream is the 128-to-32-bit unstacker (valid/ready).
- Optionally triggers key expansion before the first block, counts blocks, and runs a per-operation watchdog.
- Reports busy, done and error to the HWPE control slave.

Parameters:
- CNT_W, 16: width of block count and block counter.
- TO_W, 8: width of the watchdog counter.
- TIMEOUT, 200: maximum cycles allowed for a key or block operation before error; must be below 2**TO_W.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- clr_i  in  1  synchronous soft clear; abort job
- start_i  in  1  start job (pulse)
- nblocks_i  in  CNT_W  blocks in job; sampled on accepted start_i
- rekey_i  in  1  run key expansion first; sampled on accepted start_i
- in_valid_i  in  1  stacker block valid
- in_ready_o  out  1  controller accepts block
- in_data_i  in  128  block from stacker
- key_start_o  out  1  key expansion start pulse
- key_done_i  in  1  key expansion finished
- core_start_o  out  1  block cipher start pulse
- core_data_o  out  128  block to core; registered
- core_done_i  in  1  core result valid (1-cycle)
- core_data_i  in  128  core result
- out_valid_o  out  1  result valid to unstacker
- out_ready_i  in  1  unstacker accepts
- out_data_o  out  128  registered result
- busy_o  out  1  job in progress
- done_o  out  1  1-cycle job-complete pulse
- err_o  out  1  sticky watchdog error
- blk_cnt_o  out  CNT_W  blocks delivered downstream in current job

Behaviour:
- Reset (rst_i high, async): state IDLE. All outputs, data registers and counters are 0.
- clr_i: synchronous. Priority is below rst_i and above everything else. Effect is identical to reset, including clearing err_o.
- States: IDLE, KEY, FETCH, RUN, DRAIN, FINISH, ERR.
- IDLE:
  - start_i latches nblocks_i into rem_r, latches rekey_i, and clears blk_cnt_o and err_o.
  - Next state: FINISH if nblocks_i==0. Otherwise KEY if rekey_i, else FETCH.
  - start_i in any other state is ignored.
- KEY:
  - key_start_o is high for exactly the first cycle in KEY.
  - On key_done_i: go to FETCH.
- FETCH:
  - in_ready_o=1.
  - On in_valid_i: latch in_data_i into core_data_o and go to RUN.
  - core_start_o pulses in the first RUN cycle, i.e. 1 cycle after the handshake.
- RUN:
  - On core_done_i: latch core_data_i into out_data_o and go to DRAIN.
  - out_valid_o rises the next cycle.
- DRAIN:
  - out_valid_o=1, out_data_o held stable until out_ready_i.
  - On handshake: blk_cnt_o+1, rem_r-1.
  - Next state: FINISH if rem_r was 1, else FETCH.
- FINISH: done_o=1 for one cycle, then IDLE.
- in_ready_o is 0 in every state except FETCH. There is no overlap of blocks: one block in flight.
- busy_o=1 in KEY, FETCH, RUN, DRAIN, FINISH.
- Watchdog:
  - Counter cleared on entry to KEY or RUN; increments each cycle in those states.
  - When it reaches TIMEOUT without key_done_i/core_done_i: go to ERR and set err_o.
  - If done and timeout coincide, done wins.
- ERR: busy_o=0, err_o=1. Exit only via start_i (new job) or clr_i/rst_i.
- key_done_i outside KEY and core_done_i outside RUN are ignored.
- blk_cnt_o holds its final value after FINISH until the next accepted start_i.

Decomposition:
- Shared package aes_ctrl_pkg:
  - state enum ctrl_state_e (IDLE, KEY, FETCH, RUN, DRAIN, FINISH, ERR).
  - localparam BLOCK_W=128.
- One sub-module aes_watchdog: clear, enable, TIMEOUT compare, expired output; parameterised by TO_W and TIMEOUT.

Test Plan:
- Reset then start_i with nblocks_i=3, rekey_i=0. Stacker supplies blocks A,B,C; core returns A^1,B^1,C^1 after 10 cycles; out_ready_i=1. Expect:
  - 3 core_start_o pulses.
  - out_data_o sequence A^1,B^1,C^1.
  - blk_cnt_o=3.
  - done_o 1 cycle after the last out handshake, then busy_o=0.
- start_i with rekey_i=1, nblocks_i=1, key_done_i after 5 cycles. Expect key_start_o pulse in the cycle after start, in_ready_o low until key_done_i, then a normal single block.
- start_i with nblocks_i=0. Expect done_o 1 cycle later, no key_start_o/core_start_o, blk_cnt_o=0.
- core_done_i withheld. Expect:
  - ERR after TIMEOUT=200 cycles of RUN, err_o=1, busy_o=0.
  - A later start_i with nblocks_i=1 clears err_o and completes normally.
- Backpressure: out_ready_i low for 20 cycles in DRAIN. Expect out_data_o stable, in_ready_o=0, no second core_start_o.
- Assert clr_i in RUN, then core_done_i the next cycle. Expect all outputs 0, state IDLE, the late core_done_i ignored. Async rst_i mid-DRAIN clears outputs without a clock edge.
